// File: rtl/operand_fetch.sv
// operand_fetch: decode-stage operand fetch with a register scoreboard.
//
// An instruction is captured when en is seen high in IDLE. Its source
// registers are checked against the pending scoreboard; while any source
// has a write in flight the unit stalls. Once the sources are clear, the
// operands are read from the register-file snapshot. ready then pulses for
// one cycle, and the destination is marked pending if the opcode writes.
// Writeback retires pending bits through wb_done/wb_op/wb_addr.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   decode request, held high until ready is seen
//   instr      in   [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt, [7:0] imm8
//   regs_flat  in   register file snapshot, reg i = bits [8i+7:8i]
//   wb_done    in   writeback retire pulse
//   wb_op      in   opcode retired by writeback
//   wb_addr    in   destination register retired by writeback
//   ready      out  one-cycle pulse, op_out/rd_out/opa/opb valid
//   op_out     out  captured opcode
//   rd_out     out  captured rd
//   opa, opb   out  operand values
//   stall      out  high while waiting on a pending source register
//   pending    out  scoreboard, bit i = write to reg i in flight
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for en; instr is captured on entry to CHECK
// CHECK    | first hazard check against pending
// STALL    | a source is pending; recheck every cycle
// ISSUE    | operands latched; ready registered out; rd marked pending
// WAIT_LOW | holding until en drops before accepting the next instr

module operand_fetch #(
  parameter logic [3:0] OP_NOP  = 4'b0000,
  parameter logic [3:0] OP_LOD  = 4'b0001,
  parameter logic [3:0] OP_STO  = 4'b0010,
  parameter logic [3:0] OP_ADD  = 4'b0011,
  parameter logic [3:0] OP_ADDI = 4'b0100,
  parameter logic [3:0] OP_LODI = 4'b0101,
  parameter logic [3:0] OP_NAND = 4'b0110
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [15:0]  instr,
  input  logic [127:0] regs_flat,
  input  logic         wb_done,
  input  logic [3:0]   wb_op,
  input  logic [3:0]   wb_addr,
  output logic         ready,
  output logic [3:0]   op_out,
  output logic [3:0]   rd_out,
  output logic [7:0]   opa,
  output logic [7:0]   opb,
  output logic         stall,
  output logic [15:0]  pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STALL,
    S_ISSUE,
    S_WAIT_LOW
  } state_t;

  state_t state, state_nxt;

  logic [15:0] instr_q;
  logic [3:0]  q_op, q_rd, q_rs, q_rt;
  logic [7:0]  q_imm;
  logic [7:0]  reg_rd, reg_rs, reg_rt;
  logic [7:0]  opa_nxt, opb_nxt;
  logic [15:0] src_mask;
  logic [15:0] set_mask, clr_mask;
  logic        hazard;
  logic        capture;
  logic        load_ops;

  function automatic logic writes_f(input logic [3:0] op);
    return (op == OP_LOD) || (op == OP_ADD) || (op == OP_ADDI) ||
           (op == OP_LODI) || (op == OP_NAND);
  endfunction

  assign q_op  = instr_q[15:12];
  assign q_rd  = instr_q[11:8];
  assign q_rs  = instr_q[7:4];
  assign q_rt  = instr_q[3:0];
  assign q_imm = instr_q[7:0];

  assign reg_rd = regs_flat[{q_rd, 3'b000} +: 8];
  assign reg_rs = regs_flat[{q_rs, 3'b000} +: 8];
  assign reg_rt = regs_flat[{q_rt, 3'b000} +: 8];

  // Source registers per opcode; undefined opcodes read nothing.
  always_comb begin
    src_mask = 16'h0000;
    case (q_op)
      OP_ADD, OP_NAND: begin
        src_mask[q_rs] = 1'b1;
        src_mask[q_rt] = 1'b1;
      end
      OP_ADDI: src_mask[q_rd] = 1'b1;
      OP_LOD:  src_mask[q_rs] = 1'b1;
      OP_STO: begin
        src_mask[q_rs] = 1'b1;
        src_mask[q_rd] = 1'b1;
      end
      default: src_mask = 16'h0000;
    endcase
  end

  always_comb begin
    opa_nxt = 8'h00;
    opb_nxt = 8'h00;
    case (q_op)
      OP_ADD, OP_NAND: begin
        opa_nxt = reg_rs;
        opb_nxt = reg_rt;
      end
      OP_ADDI: begin
        opa_nxt = reg_rd;
        opb_nxt = q_imm;
      end
      OP_LODI: opb_nxt = q_imm;
      OP_LOD:  opa_nxt = reg_rs;
      OP_STO: begin
        opa_nxt = reg_rs;
        opb_nxt = reg_rd;
      end
      default: begin
        opa_nxt = 8'h00;
        opb_nxt = 8'h00;
      end
    endcase
  end

  // The hazard check uses the scoreboard as it stands, before this
  // instruction's own destination is marked, so rd-as-source only stalls on
  // an older write.
  assign hazard = |(src_mask & pending);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_ops  = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          capture   = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK, S_STALL: begin
        if (hazard) begin
          state_nxt = S_STALL;
        end else begin
          load_ops  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:    state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: if (!en) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    set_mask = 16'h0000;
    clr_mask = 16'h0000;
    if (state == S_ISSUE && writes_f(q_op)) set_mask[q_rd] = 1'b1;
    if (wb_done && writes_f(wb_op))         clr_mask[wb_addr] = 1'b1;
  end

  assign stall = (state == S_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      instr_q <= 16'h0000;
      ready   <= 1'b0;
      op_out  <= 4'h0;
      rd_out  <= 4'h0;
      opa     <= 8'h00;
      opb     <= 8'h00;
      pending <= 16'h0000;
    end else begin
      state <= state_nxt;
      ready <= (state == S_ISSUE);
      if (capture) instr_q <= instr;
      if (load_ops) begin
        op_out <= q_op;
        rd_out <= q_rd;
        opa    <= opa_nxt;
        opb    <= opb_nxt;
      end
      // Set is applied after clear so a same-edge issue keeps the bit.
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [15:0]  instr;
  logic [127:0] regs_flat;
  logic         wb_done;
  logic [3:0]   wb_op;
  logic [3:0]   wb_addr;
  logic         ready;
  logic [3:0]   op_out;
  logic [3:0]   rd_out;
  logic [7:0]   opa;
  logic [7:0]   opb;
  logic         stall;
  logic [15:0]  pending;

  logic [7:0] regs [16];
  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .en(en), .instr(instr), .regs_flat(regs_flat),
    .wb_done(wb_done), .wb_op(wb_op), .wb_addr(wb_addr), .ready(ready),
    .op_out(op_out), .rd_out(rd_out), .opa(opa), .opb(opb), .stall(stall),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++) regs_flat[8*i +: 8] = regs[i];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic start(input logic [15:0] ins);
    en    = 1'b1;
    instr = ins;
  endtask

  task automatic release_en();
    en = 1'b0;
    @(negedge clk);
  endtask

  // Counts negedges until ready is seen; -1 when the budget expires.
  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready, stall, pending, op_out, rd_out, opa, opb} !== 45'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {ready, stall, pending, op_out, rd_out, opa, opb});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int cyc;
    regs[3] = 8'h12;
    regs[4] = 8'h34;
    start(16'h3134);
    wait_ready(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL add_latency: got %0d required 3", cyc); end
    checks++;
    if ({op_out, rd_out, opa, opb} !== 24'h311234) begin
      errors++; $display("FAIL add_operands: got %h required 311234", {op_out, rd_out, opa, opb});
    end
    checks++;
    if (pending !== 16'h0002) begin errors++; $display("FAIL add_pending: got %h required 0002", pending); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL add_ready_pulse: got %b required 0", ready); end
    release_en();
  endtask

  task automatic test_stall();
    int cyc;
    int nready = 0;
    start(16'h6613);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    checks++;
    if (stall !== 1'b1 || nready !== 0) begin
      errors++; $display("FAIL stall_hold: got stall=%b readies=%0d required stall=1 readies=0", stall, nready);
    end
    regs[1] = 8'h46;
    wb_done = 1'b1; wb_op = 4'h3; wb_addr = 4'h1;
    @(negedge clk);
    wb_done = 1'b0;
    checks++;
    if (ready !== 1'b0 || pending !== 16'h0000) begin
      errors++; $display("FAIL stall_clear: got ready=%b pending=%h required 0/0000", ready, pending);
    end
    wait_ready(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL stall_release_latency: got %0d required 2", cyc); end
    checks++;
    if ({op_out, rd_out, opa, opb} !== 24'h664612) begin
      errors++; $display("FAIL stall_operands: got %h required 664612", {op_out, rd_out, opa, opb});
    end
    checks++;
    if (pending !== 16'h0040 || stall !== 1'b0) begin
      errors++; $display("FAIL stall_pending: got %h stall=%b required 0040 stall=0", pending, stall);
    end
    release_en();
  endtask

  task automatic test_lodi_sto();
    int cyc;
    start(16'h55A5);
    wait_ready(cyc);
    checks++;
    if (cyc !== 3 || {op_out, rd_out, opa, opb} !== 24'h5500A5) begin
      errors++; $display("FAIL lodi: got cyc=%0d %h required 3 5500A5", cyc, {op_out, rd_out, opa, opb});
    end
    checks++;
    if (pending !== 16'h0060) begin errors++; $display("FAIL lodi_pending: got %h required 0060", pending); end
    release_en();
    regs[2] = 8'h77;
    regs[7] = 8'h99;
    start(16'h2720);
    wait_ready(cyc);
    checks++;
    if (cyc !== 3 || {op_out, rd_out, opa, opb} !== 24'h277799) begin
      errors++; $display("FAIL sto: got cyc=%0d %h required 3 277799", cyc, {op_out, rd_out, opa, opb});
    end
    checks++;
    if (pending !== 16'h0060) begin errors++; $display("FAIL sto_pending: got %h required 0060", pending); end
    release_en();
  endtask

  task automatic test_wb_clear();
    wb_done = 1'b1; wb_op = 4'h2; wb_addr = 4'h5;
    @(negedge clk);
    checks++;
    if (pending !== 16'h0060) begin errors++; $display("FAIL clear_nonwriting: got %h required 0060", pending); end
    wb_op = 4'h1; wb_addr = 4'h9;
    @(negedge clk);
    checks++;
    if (pending !== 16'h0060) begin errors++; $display("FAIL clear_already_clear: got %h required 0060", pending); end
    wb_op = 4'h1; wb_addr = 4'h5;
    @(negedge clk);
    wb_done = 1'b0;
    checks++;
    if (pending !== 16'h0040) begin errors++; $display("FAIL clear_lod: got %h required 0040", pending); end
  endtask

  task automatic test_set_wins();
    int nready = 0;
    start(16'h4210);
    @(negedge clk);
    @(negedge clk);
    wb_done = 1'b1; wb_op = 4'h5; wb_addr = 4'h2;
    @(negedge clk);
    wb_done = 1'b0;
    checks++;
    if (ready !== 1'b1 || pending !== 16'h0044) begin
      errors++; $display("FAIL set_wins: got ready=%b pending=%h required 1 0044", ready, pending);
    end
    checks++;
    if ({op_out, rd_out, opa, opb} !== 24'h427710) begin
      errors++; $display("FAIL addi_operands: got %h required 427710", {op_out, rd_out, opa, opb});
    end
    instr = 16'h6FFF;
    regs[2] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    checks++;
    if (nready !== 0 || {op_out, rd_out, opa, opb} !== 24'h427710) begin
      errors++; $display("FAIL hold_outputs: got readies=%0d %h required 0 427710", nready, {op_out, rd_out, opa, opb});
    end
    release_en();
  endtask

  task automatic test_own_rd_and_undef();
    int cyc;
    start(16'h3888);
    wait_ready(cyc);
    checks++;
    if (cyc !== 3 || pending !== 16'h0144) begin
      errors++; $display("FAIL own_rd_source: got cyc=%0d pending=%h required 3 0144", cyc, pending);
    end
    release_en();
    start(16'hF123);
    wait_ready(cyc);
    checks++;
    if (cyc !== 3 || {op_out, rd_out, opa, opb} !== 24'hF10000 || pending !== 16'h0144) begin
      errors++; $display("FAIL undefined_op: got cyc=%0d %h pending=%h required 3 F10000 0144",
                         cyc, {op_out, rd_out, opa, opb}, pending);
    end
    release_en();
  endtask

  task automatic test_reset_mid_stall();
    int cyc;
    int nready = 0;
    for (int r = 0; r < 16; r++) begin
      start({4'h5, r[3:0], 8'h01});
      wait_ready(cyc);
      release_en();
    end
    checks++;
    if (pending !== 16'hFFFF) begin errors++; $display("FAIL fill_pending: got %h required FFFF", pending); end
    start(16'h3012);
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b required 1", stall); end
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    checks++;
    if ({ready, stall, pending, op_out, rd_out, opa, opb} !== 45'h0) begin
      errors++; $display("FAIL reset_mid_stall: got %h required 0",
                         {ready, stall, pending, op_out, rd_out, opa, opb});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    checks++;
    if (nready !== 0) begin errors++; $display("FAIL reset_no_ready: got %0d required 0", nready); end
    regs[3] = 8'h12;
    regs[4] = 8'h34;
    start(16'h3134);
    wait_ready(cyc);
    checks++;
    if (cyc !== 3 || opa !== 8'h12 || opb !== 8'h34 || pending !== 16'h0002) begin
      errors++; $display("FAIL add_after_reset: got cyc=%0d opa=%h opb=%h pending=%h required 3 12 34 0002",
                         cyc, opa, opb, pending);
    end
    release_en();
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    instr   = 16'h0000;
    wb_done = 1'b0;
    wb_op   = 4'h0;
    wb_addr = 4'h0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_add();
    test_stall();
    test_lodi_sto();
    test_wb_clear();
    test_set_wins();
    test_own_rd_and_undef();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
